// File: rtl/dlx_pkg.sv
// Shared DLX pipeline types: instruction/PC widths, the NOP encoding and the
// fetch word handed from IF to ID.
package dlx_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  localparam logic [INSTR_W-1:0] DLX_NOP = 32'h5400_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc4;
  } fetch_word_t;

endpackage

// File: rtl/fetch_queue.sv
// Instruction prefetch queue between IF and ID: circular buffer of fetch words
// with valid/ready on both sides and a single-cycle flush for taken branches.
module fetch_queue
  import dlx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IW    = INSTR_W,
  parameter int AW    = PC_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IW-1:0]            in_instr,
  input  logic [AW-1:0]            in_pc4,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IW-1:0]            out_instr,
  output logic [AW-1:0]            out_pc4,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_word_t       r_mem [DEPTH];
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;

  logic              w_push;
  logic              w_pop;
  fetch_word_t       w_wr_word;
  fetch_word_t       w_rd_word;

  // in_ready depends only on the held count so out_ready never reaches fetch
  assign in_ready  = (r_count != CW'(DEPTH));
  assign out_valid = (r_count != '0);
  assign count     = r_count;

  assign w_push = in_valid & in_ready & ~flush;
  assign w_pop  = out_valid & out_ready & ~flush;

  assign w_wr_word.instr = in_instr;
  assign w_wr_word.pc4   = in_pc4;

  assign w_rd_word = r_mem[r_rd_ptr];
  assign out_instr = w_rd_word.instr;
  assign out_pc4   = w_rd_word.pc4;

  // Control state: reset and flush both return to empty
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is never cleared; count alone decides which entries are live
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_wr_word;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed stimulus plus a random run, with a reference
// queue consumed by an independent monitor on the falling edge.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] in_instr, in_pc4, out_instr, out_pc4;
  logic [2:0]  count;

  fetch_queue #(.DEPTH(DEPTH), .IW(32), .AW(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc4(in_pc4),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc4(out_pc4),
    .count(count)
  );

  always #5 clk = ~clk;

  logic [63:0] exp_q[$];
  int          nchk = 0;
  int          npass = 0;
  logic        mon_en = 1'b0;

  // Monitor: state agrees with the model, and every consumed head matches it
  always @(negedge clk) begin
    if (mon_en) begin
      nchk++;
      if (count == 3'(exp_q.size()) && out_valid == (exp_q.size() != 0) &&
          in_ready == (exp_q.size() != DEPTH) && count <= 3'(DEPTH))
        npass++;
      else
        $display("FAIL state: count=%0d out_valid=%0b in_ready=%0b, required count=%0d",
                 count, out_valid, in_ready, exp_q.size());
      if (out_valid && out_ready && !flush && !reset && exp_q.size() != 0) begin
        nchk++;
        if ({out_instr, out_pc4} === exp_q[0]) npass++;
        else $display("FAIL pop_data: got %h/%h, required %h/%h",
                      out_instr, out_pc4, exp_q[0][63:32], exp_q[0][31:0]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act === req) npass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  // One clock: drive inputs, then advance the reference model across the edge
  task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                     input logic ordy, input logic fl, input logic rs);
    bit acc, pp;
    in_valid = v; in_instr = ins; in_pc4 = pc;
    out_ready = ordy; flush = fl; reset = rs;
    @(posedge clk);
    if (rs || fl) begin
      exp_q.delete();
    end else begin
      acc = v && (exp_q.size() < DEPTH);
      pp  = ordy && (exp_q.size() != 0);
      if (pp)  void'(exp_q.pop_front());
      if (acc) exp_q.push_back({ins, pc});
    end
    #1;
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    mon_en = 1'b1;

    // Single push becomes visible one edge later
    cyc(1, 32'h2001_0005, 32'h4, 0, 0, 0);
    chk("first_valid", 32'(out_valid), 1);
    chk("first_instr", out_instr, 32'h2001_0005);
    chk("first_pc4", out_pc4, 32'h4);
    chk("first_count", 32'(count), 1);
    cyc(0, 0, 0, 1, 0, 0);
    chk("drain_count", 32'(count), 0);

    // Fill to full, refused fifth push, full-with-pop takes no word
    for (int i = 0; i < 4; i++) cyc(1, 32'h1000_0000 + 32'(i), 32'h100 + 32'(4*i), 0, 0, 0);
    chk("full_count", 32'(count), 4);
    chk("full_in_ready", 32'(in_ready), 0);
    cyc(1, 32'hDEAD_BEEF, 32'hFFC, 0, 0, 0);
    chk("fifth_refused", 32'(count), 4);
    cyc(1, 32'hBAD0_0001, 32'hFF8, 1, 0, 0);
    chk("full_pop_count", 32'(count), 3);
    chk("full_pop_head", out_instr, 32'h1000_0001);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0);
    chk("empty_valid", 32'(out_valid), 0);

    // Streaming through a pointer wrap: occupancy stays at one, no bubbles
    cyc(1, 32'h3000_0000, 32'h200, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      cyc(1, 32'h3000_0000 + 32'(i), 32'h200 + 32'(4*i), 1, 0, 0);
      chk("stream_count", 32'(count), 1);
      chk("stream_head", out_instr, 32'h3000_0000 + 32'(i));
    end
    cyc(0, 0, 0, 1, 0, 0);

    // Flush with incoming word and pop in the same cycle
    for (int i = 0; i < 3; i++) cyc(1, 32'h4000_0000 + 32'(i), 32'h300 + 32'(4*i), 0, 0, 0);
    cyc(1, 32'h4444_4444, 32'h3FC, 1, 1, 0);
    chk("flush_count", 32'(count), 0);
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_in_ready", 32'(in_ready), 1);
    cyc(1, 32'h5000_0001, 32'h400, 0, 0, 0);
    chk("post_flush_head", out_instr, 32'h5000_0001);
    chk("post_flush_pc4", out_pc4, 32'h400);
    cyc(0, 0, 0, 1, 0, 0);

    // Reset while full and popping
    for (int i = 0; i < 4; i++) cyc(1, 32'h6000_0000 + 32'(i), 32'h500 + 32'(4*i), 0, 0, 0);
    cyc(1, 32'h6666_6666, 32'h5F0, 1, 0, 1);
    chk("reset_mid_count", 32'(count), 0);
    chk("reset_mid_valid", 32'(out_valid), 0);
    chk("reset_mid_in_ready", 32'(in_ready), 1);
    cyc(1, 32'h7000_0000, 32'h600, 0, 1, 1);
    chk("flush_and_reset", 32'(count), 0);

    // Random traffic checked by the monitor against the reference queue
    for (int i = 0; i < 10000; i++)
      cyc(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 2) != 0),
          $urandom_range(0, 31) == 0, $urandom_range(0, 199) == 0);
    cyc(0, 0, 0, 0, 0, 0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
